// File: rtl/dfr_reservoir_sequencer_if.sv
// Signal bundle between the DFR run-time sequencer and its surroundings:
// config/status, input RAM read port, reservoir step port, history RAM write port, matmul handshake.
interface dfr_reservoir_sequencer_if #(
  parameter int ADDR_WIDTH         = 14,
  parameter int DATA_WIDTH         = 32,
  parameter int HISTORY_ADDR_WIDTH = 20
);
  logic                          start;
  logic                          abort;
  logic [ADDR_WIDTH-1:0]         num_samples;
  logic                          busy;
  logic                          done;
  logic                          history_overflow;
  logic [ADDR_WIDTH-1:0]         input_mem_addr;
  logic [DATA_WIDTH-1:0]         input_mem_dout;
  logic                          reservoir_en;
  logic [DATA_WIDTH-1:0]         reservoir_din;
  logic [DATA_WIDTH-1:0]         reservoir_dout;
  logic                          history_wen;
  logic [HISTORY_ADDR_WIDTH-1:0] history_addr;
  logic [DATA_WIDTH-1:0]         history_din;
  logic                          mm_start;
  logic                          mm_busy;

  modport master (
    input  start, abort, num_samples, input_mem_dout, reservoir_dout, mm_busy,
    output busy, done, history_overflow, input_mem_addr, reservoir_en, reservoir_din,
           history_wen, history_addr, history_din, mm_start
  );

  modport slave (
    output start, abort, num_samples, input_mem_dout, reservoir_dout, mm_busy,
    input  busy, done, history_overflow, input_mem_addr, reservoir_en, reservoir_din,
           history_wen, history_addr, history_din, mm_start
  );
endinterface

// File: rtl/dfr_reservoir_sequencer.sv
// DFR run-time sequencer: streams N samples through the reservoir (VIRTUAL_NODES cycles each),
// logs every reservoir output to the history RAM, then launches the matrix multiply and waits.
module dfr_reservoir_sequencer #(
  parameter int ADDR_WIDTH         = 14,
  parameter int DATA_WIDTH         = 32,
  parameter int HISTORY_ADDR_WIDTH = 20,
  parameter int VIRTUAL_NODES      = 10
) (
  input logic                    S_AXI_ACLK,
  input logic                    S_AXI_ARESETN,
  dfr_reservoir_sequencer_if.master bus
);
  localparam int NCW = $clog2(VIRTUAL_NODES + 1);

  typedef enum logic [2:0] {
    IDLE, RD_ADDR, RD_DATA, NODES, MM_START, MM_WAIT, DONE
  } state_t;

  state_t                        state, state_nx;
  logic [ADDR_WIDTH-1:0]         n_lat, sample_idx, next_idx, addr_q;
  logic [DATA_WIDTH-1:0]         sample_reg;
  logic [HISTORY_ADDR_WIDTH-1:0] hist_ptr;
  logic [NCW-1:0]                node_cnt;
  logic                          ovf, mm_first, last_node, kill, accept;

  assign next_idx  = sample_idx + ADDR_WIDTH'(1);
  assign last_node = (node_cnt == NCW'(VIRTUAL_NODES - 1));
  assign kill      = bus.abort && (state != IDLE);
  assign accept    = (state == IDLE) && bus.start && !bus.abort;

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) state <= IDLE;
    else                state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:     if (accept) state_nx = (bus.num_samples == '0) ? DONE : RD_ADDR;
      RD_ADDR:  state_nx = RD_DATA;
      RD_DATA:  state_nx = NODES;
      NODES:    if (last_node) state_nx = (next_idx == n_lat) ? MM_START : RD_ADDR;
      MM_START: state_nx = MM_WAIT;
      // engine needs a cycle to register mm_start before its busy is meaningful
      MM_WAIT:  if (!mm_first && !bus.mm_busy) state_nx = DONE;
      DONE:     state_nx = IDLE;
      default:  state_nx = IDLE;
    endcase
    if (kill) state_nx = IDLE;
  end

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      n_lat      <= '0;
      sample_idx <= '0;
      addr_q     <= '0;
      sample_reg <= '0;
      hist_ptr   <= '0;
      node_cnt   <= '0;
      ovf        <= 1'b0;
      mm_first   <= 1'b0;
    end else if (!kill) begin
      case (state)
        IDLE: if (accept) begin
          n_lat      <= bus.num_samples;
          sample_idx <= '0;
          ovf        <= 1'b0;
          if (bus.num_samples != '0) begin
            hist_ptr <= '0;
            addr_q   <= '0;
          end
        end
        RD_DATA: begin
          sample_reg <= bus.input_mem_dout;
          node_cnt   <= '0;
        end
        NODES: begin
          hist_ptr <= hist_ptr + HISTORY_ADDR_WIDTH'(1);
          if (&hist_ptr) ovf <= 1'b1;
          node_cnt <= node_cnt + NCW'(1);
          if (last_node) begin
            sample_idx <= next_idx;
            // address is registered one state ahead so the RAM sees it during RD_ADDR
            if (next_idx != n_lat) addr_q <= next_idx;
          end
        end
        MM_START: mm_first <= 1'b1;
        MM_WAIT:  mm_first <= 1'b0;
        default: ;
      endcase
    end
  end

  always_comb begin
    bus.busy         = (state != IDLE);
    bus.done         = (state == DONE);
    bus.reservoir_en = (state == NODES);
    bus.history_wen  = (state == NODES);
    bus.mm_start     = (state == MM_START);
  end

  assign bus.history_overflow = ovf;
  assign bus.input_mem_addr   = addr_q;
  assign bus.reservoir_din    = sample_reg;
  assign bus.history_addr     = hist_ptr;
  assign bus.history_din      = bus.reservoir_dout;
endmodule

// File: tb/tb_dfr_reservoir_sequencer.sv
// Bench for dfr_reservoir_sequencer: directed + randomized runs against an arithmetic model of
// history writes (address = write index mod depth, data = sample of index/VN) and run timing.
module tb_dfr_reservoir_sequencer;
  localparam int AW = 14, DW = 32, HAW = 6, VN = 10;
  localparam int HDEPTH = 1 << HAW;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dfr_reservoir_sequencer_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .HISTORY_ADDR_WIDTH(HAW)) bus ();

  dfr_reservoir_sequencer #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .HISTORY_ADDR_WIDTH(HAW),
                            .VIRTUAL_NODES(VN)) u_dut (
    .S_AXI_ACLK(clk), .S_AXI_ARESETN(rst_n), .bus(bus));

  int checks = 0, errors = 0, cyc = 0;
  logic [DW-1:0] mem [16];
  int            wa_q[$];
  logic [DW-1:0] wd_q[$];
  int done_q[$], ms_q[$];
  int hd_bad, en_bad, busy_n, busy_len, busy_cnt = 0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    bus.input_mem_dout <= mem[bus.input_mem_addr[3:0]];
  end

  // observer plus matmul-busy and reservoir-output stimulus
  always @(negedge clk) begin
    if (bus.history_wen) begin
      wa_q.push_back(int'(bus.history_addr));
      wd_q.push_back(bus.reservoir_din);
      if (bus.history_din !== bus.reservoir_dout) hd_bad++;
    end
    if (bus.reservoir_en !== bus.history_wen) en_bad++;
    if (bus.done) done_q.push_back(cyc);
    if (bus.mm_start) ms_q.push_back(cyc);
    if (bus.busy) busy_n++;
    if (busy_cnt > 0) begin bus.mm_busy = 1'b1; busy_cnt--; end
    else bus.mm_busy = 1'b0;
    if (bus.mm_start) busy_cnt = busy_len;
    bus.reservoir_dout = $urandom;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk); #1;
  endtask

  task automatic clear_mon();
    wa_q.delete(); wd_q.delete(); done_q.delete(); ms_q.delete();
    hd_bad = 0; en_bad = 0; busy_n = 0;
  endtask

  task automatic start_run(input int n, output int t);
    for (int i = 0; i < 16; i++) mem[i] = $urandom;
    @(negedge clk);
    bus.num_samples = AW'(n);
    bus.start = 1'b1;
    t = cyc;
    step();
    bus.start = 1'b0;
  endtask

  task automatic check_writes(input string tag, input int n_wr);
    int bad = 0;
    chk({tag, "_wr_cnt"}, wa_q.size(), n_wr);
    for (int w = 0; w < n_wr && w < wa_q.size(); w++)
      if (wa_q[w] != (w % HDEPTH) || wd_q[w] !== mem[w / VN]) bad++;
    chk({tag, "_wr_data"}, bad, 0);
  endtask

  task automatic full_run(input string tag, input int n, input int len, input int extra_start);
    int t, exp_done;
    bit ok = 0;
    clear_mon();
    busy_len = len;
    start_run(n, t);
    exp_done = (n == 0) ? t + 1 : t + n * (VN + 2) + 1 + ((len > 1) ? len : 1) + 2;
    chk({tag, "_busy_rise"}, bus.busy, 1'b1);
    if (n != 0) chk({tag, "_addr0"}, bus.input_mem_addr, 0);
    for (int k = 0; k < exp_done - t + 100; k++) begin
      if (done_q.size() > 0) begin ok = 1; break; end
      bus.start = (extra_start != 0 && cyc == t + extra_start);
      step();
    end
    bus.start = 1'b0;
    chk({tag, "_done_seen"}, ok, 1'b1);
    chk({tag, "_done_cyc"}, ok ? done_q[0] : -1, exp_done);
    while (cyc < exp_done + 1) step();
    chk({tag, "_busy_fall"}, bus.busy, 1'b0);
    chk({tag, "_busy_cycles"}, busy_n, exp_done - t);
    chk({tag, "_done_cnt"}, done_q.size(), 1);
    chk({tag, "_mm_cnt"}, ms_q.size(), (n == 0) ? 0 : 1);
    chk({tag, "_passthru"}, hd_bad + en_bad, 0);
    chk({tag, "_ovf"}, bus.history_overflow, (n * VN > HDEPTH));
    check_writes(tag, n * VN);
  endtask

  initial begin
    int t;
    bus.start = 1'b0; bus.abort = 1'b0; bus.num_samples = '0;
    #1;
    chk("reset_ctrl", {bus.busy, bus.done, bus.history_wen, bus.reservoir_en, bus.mm_start,
                       bus.history_overflow}, 0);
    chk("reset_addr", {bus.history_addr, bus.input_mem_addr}, 0);
    chk("reset_din", bus.reservoir_din, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    step();

    full_run("t1", 3, 0, 0);
    full_run("t2_zero", 0, 0, 0);
    full_run("t3_mmbusy", 2, 50, 10);
    repeat (3) full_run("rand", $urandom_range(1, 4), $urandom_range(0, 8), 0);
    full_run("t5_wrap", 7, 0, 0);
    step();
    chk("t5_ovf_sticky", bus.history_overflow, 1'b1);

    // abort in the 5th node cycle of the second sample
    clear_mon();
    start_run(3, t);
    chk("t4_ovf_clear", bus.history_overflow, 1'b0);
    while (cyc < t + 19) step();
    bus.abort = 1'b1;
    step();
    bus.abort = 1'b0;
    chk("t4_abort_idle", {bus.busy, bus.history_wen, bus.reservoir_en}, 0);
    repeat (5) step();
    chk("t4_no_done", done_q.size() + ms_q.size(), 0);
    chk("t4_hold_din", bus.reservoir_din, mem[1]);
    check_writes("t4_abort", 15);
    full_run("t4_restart", 2, 0, 0);

    // abort wins over start in IDLE
    clear_mon();
    @(negedge clk);
    bus.num_samples = AW'(2); bus.start = 1'b1; bus.abort = 1'b1;
    step();
    bus.start = 1'b0; bus.abort = 1'b0;
    chk("abort_vs_start", bus.busy, 1'b0);
    repeat (4) step();
    chk("abort_vs_start_quiet", wa_q.size() + busy_n, 0);

    // asynchronous reset in the middle of NODES
    clear_mon();
    start_run(2, t);
    while (cyc < t + 5) step();
    #1 rst_n = 1'b0;
    #1;
    chk("t6_rst_ctrl", {bus.busy, bus.done, bus.history_wen, bus.reservoir_en, bus.mm_start,
                        bus.history_overflow}, 0);
    chk("t6_rst_addr", {bus.history_addr, bus.input_mem_addr}, 0);
    chk("t6_rst_din", bus.reservoir_din, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    step();
    chk("t6_idle", bus.busy, 1'b0);
    repeat (4) step();
    chk("t6_no_done", done_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
